mc_control: RTL and testbench

- Multicycle MIPS control unit that drives the execution-stage ALU's 5-bit aluctrl and consumes its zero flag.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Generates datapath enables and handshakes with a single instruction/data memory port.
- Sits between the instruction register and the execution ALU, register file, PC and memory.

---
 rtl/mc_control_pkg.sv | 82 ++++++++
 rtl/alu_decode.sv | 47 ++++
 rtl/mc_control.sv | 159 +++++++++++++++
 tb/tb_mc_control.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// State enum, ALU operation codes, opcode/funct values and mux selects.
package mc_control_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_R_EXEC,
      S_R_WB,
      S_I_EXEC,
      S_I_WB,
      S_MEM_ADDR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_BRANCH,
      S_JUMP,
      S_TRAP
   } state_e;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_ADD,
      CLS_SUB,
      CLS_R,
      CLS_I
   } alu_cls_e;

   localparam logic [4:0] ALU_AND     = 5'b00000;
   localparam logic [4:0] ALU_OR      = 5'b00001;
   localparam logic [4:0] ALU_ADD     = 5'b00010;
   localparam logic [4:0] ALU_SUB     = 5'b00110;
   localparam logic [4:0] ALU_PASS_D2 = 5'b00111;
   localparam logic [4:0] ALU_NOR     = 5'b01100;
   localparam logic [4:0] ALU_SLL     = 5'b01101;
   localparam logic [4:0] ALU_SRL     = 5'b01110;
   localparam logic [4:0] ALU_SRA     = 5'b01111;
   localparam logic [4:0] ALU_SLT     = 5'b10000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   localparam logic [1:0] PCS_ALU  = 2'b00;
   localparam logic [1:0] PCS_BR   = 2'b01;
   localparam logic [1:0] PCS_JMP  = 2'b10;
   localparam logic [1:0] PCS_TRAP = 2'b11;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   function automatic logic is_itype(input logic [5:0] op);
      return op == OP_ADDI || op == OP_ADDIU ||
             op == OP_ANDI || op == OP_ORI ||
             op == OP_SLTI || op == OP_LUI;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Maps the state's ALU class plus opcode/funct to an ALU operation.
// legal drops when an R funct or I opcode has no mapping.
module alu_decode
   import mc_control_pkg::*;
(
   input  alu_cls_e    cls,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output logic [4:0]  aluctrl,
   output logic        legal
);

   always_comb begin
      aluctrl = ALU_AND;
      legal   = 1'b1;
      case (cls)
         CLS_ADD: aluctrl = ALU_ADD;
         CLS_SUB: aluctrl = ALU_SUB;
         CLS_R: begin
            case (funct)
               FN_ADD, FN_ADDU: aluctrl = ALU_ADD;
               FN_SUB, FN_SUBU: aluctrl = ALU_SUB;
               FN_AND:          aluctrl = ALU_AND;
               FN_OR:           aluctrl = ALU_OR;
               FN_NOR:          aluctrl = ALU_NOR;
               FN_SLT:          aluctrl = ALU_SLT;
               FN_SLL:          aluctrl = ALU_SLL;
               FN_SRL:          aluctrl = ALU_SRL;
               FN_SRA:          aluctrl = ALU_SRA;
               default:         legal   = 1'b0;
            endcase
         end
         CLS_I: begin
            case (opcode)
               OP_ADDI, OP_ADDIU: aluctrl = ALU_ADD;
               OP_ANDI:           aluctrl = ALU_AND;
               OP_ORI:            aluctrl = ALU_OR;
               OP_SLTI:           aluctrl = ALU_SLT;
               OP_LUI:            aluctrl = ALU_PASS_D2;
               default:           legal   = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM driving datapath enables and the memory port.
// Define MC_CONTROL_TRAP_EN to trap illegal instructions instead of NOP.
module mc_control
   import mc_control_pkg::*;
#(
   parameter int ALUCTRL_W = 5,
   parameter int OP_W      = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OP_W-1:0]      opcode,
   input  logic [OP_W-1:0]      funct,
   input  logic                 zero_in,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 i_or_d,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic [1:0]           pc_source,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [ALUCTRL_W-1:0] aluctrl,
   output logic                 reg_write,
   output logic                 reg_dst,
   output logic                 mem_to_reg,
   output logic                 illegal
);

`ifdef MC_CONTROL_TRAP_EN
   localparam state_e ILL_NEXT = S_TRAP;
`else
   localparam state_e ILL_NEXT = S_FETCH;
`endif

   state_e     state, next;
   alu_cls_e   cls;
   logic [4:0] dec_alu;
   logic       dec_legal;

   alu_decode u_dec (
      .cls     (cls),
      .opcode  (opcode),
      .funct   (funct),
      .aluctrl (dec_alu),
      .legal   (dec_legal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next;
   end

   always_comb begin
      case (state)
         S_FETCH, S_DECODE, S_MEM_ADDR: cls = CLS_ADD;
         S_BRANCH:                      cls = CLS_SUB;
         S_R_EXEC:                      cls = CLS_R;
         S_I_EXEC:                      cls = CLS_I;
         default:                       cls = CLS_NONE;
      endcase
   end

   always_comb begin
      next = state;
      case (state)
         S_IDLE:  next = S_FETCH;
         S_FETCH: if (mem_ready) next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     next = S_R_EXEC;
               OP_LW, OP_SW: next = S_MEM_ADDR;
               OP_BEQ,
               OP_BNE:       next = S_BRANCH;
               OP_J:         next = S_JUMP;
               default:      next = is_itype(opcode) ? S_I_EXEC
                                                     : ILL_NEXT;
            endcase
         end
         S_R_EXEC:    next = dec_legal ? S_R_WB : ILL_NEXT;
         S_I_EXEC:    next = S_I_WB;
         S_MEM_ADDR:  next = (opcode == OP_SW) ? S_MEM_WRITE
                                               : S_MEM_READ;
         S_MEM_READ:  if (mem_ready) next = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready) next = S_FETCH;
         S_R_WB, S_I_WB, S_MEM_WB,
         S_BRANCH, S_JUMP, S_TRAP:
                      next = S_FETCH;
         default:     next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_source  = PCS_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      aluctrl    = ALUCTRL_W'(dec_alu);
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_IMM_SH;
         S_R_EXEC: alu_src_a = 1'b1;
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_I_EXEC, S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_I_WB: reg_write = 1'b1;
         S_MEM_READ: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            i_or_d  = 1'b1;
         end
         // Only output that depends on a live datapath flag
         S_BRANCH: begin
            alu_src_a = 1'b1;
            pc_source = PCS_BR;
            pc_write  = (opcode == OP_BNE) ? ~zero_in : zero_in;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCS_JMP;
         end
`ifdef MC_CONTROL_TRAP_EN
         S_TRAP: begin
            illegal   = 1'b1;
            pc_write  = 1'b1;
            pc_source = PCS_TRAP;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: a per-instruction model expands each
// instruction into the expected per-cycle control words.
module tb_mc_control;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [4:0] aluctrl;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       illegal;
   } ctl_t;

   typedef struct {
      ctl_t  c;
      bit    rdy;
      string tag;
   } step_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero_in = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
   logic [1:0] pc_source, alu_src_b;
   logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
   logic [4:0] aluctrl;
   ctl_t       got;

   int n_chk = 0;
   int n_fail = 0;
   step_t q[$];

   always #5 clk = ~clk;

   mc_control dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct      (funct),
      .zero_in    (zero_in),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .i_or_d     (i_or_d),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_source  (pc_source),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .aluctrl    (aluctrl),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .illegal    (illegal)
   );

   assign got = {mem_req, mem_we, i_or_d, ir_write, pc_write,
                 pc_source, alu_src_a, alu_src_b, aluctrl,
                 reg_write, reg_dst, mem_to_reg, illegal};

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ALU op for an R-type funct; -1 when the funct is not decodable
   function automatic int r_alu(input logic [5:0] f);
      case (f)
         6'h20, 6'h21: return 5'b00010;
         6'h22, 6'h23: return 5'b00110;
         6'h24:        return 5'b00000;
         6'h25:        return 5'b00001;
         6'h27:        return 5'b01100;
         6'h2a:        return 5'b10000;
         6'h00:        return 5'b01101;
         6'h02:        return 5'b01110;
         6'h03:        return 5'b01111;
         default:      return -1;
      endcase
   endfunction

   function automatic int i_alu(input logic [5:0] op);
      case (op)
         6'h08, 6'h09: return 5'b00010;
         6'h0c:        return 5'b00000;
         6'h0d:        return 5'b00001;
         6'h0a:        return 5'b10000;
         6'h0f:        return 5'b00111;
         default:      return -1;
      endcase
   endfunction

   task automatic push(input ctl_t c, input bit r, input string t);
      step_t s;
      s.c = c;
      s.rdy = r;
      s.tag = t;
      q.push_back(s);
   endtask

   task automatic push_ill();
`ifdef MC_CONTROL_TRAP_EN
      ctl_t c = '0;
      c.illegal = 1'b1;
      c.pc_write = 1'b1;
      c.pc_source = 2'b11;
      push(c, 1'($urandom), "trap");
`endif
   endtask

   task automatic build(input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int wf, input int wm);
      ctl_t c;
      int a;
      for (int i = 0; i <= wf; i++) begin
         c = '0;
         c.mem_req = 1'b1;
         c.alu_src_b = 2'b01;
         c.aluctrl = 5'b00010;
         c.ir_write = (i == wf);
         c.pc_write = (i == wf);
         push(c, i == wf, "fetch");
      end
      c = '0;
      c.aluctrl = 5'b00010;
      c.alu_src_b = 2'b11;
      push(c, 1'($urandom), "decode");
      if (op == 6'h00) begin
         a = r_alu(fn);
         c = '0;
         c.alu_src_a = 1'b1;
         c.aluctrl = (a < 0) ? 5'd0 : 5'(a);
         push(c, 1'($urandom), "r_exec");
         if (a < 0) push_ill();
         else begin
            c = '0;
            c.reg_write = 1'b1;
            c.reg_dst = 1'b1;
            push(c, 1'($urandom), "r_wb");
         end
      end else if (op == 6'h23 || op == 6'h2b) begin
         c = '0;
         c.aluctrl = 5'b00010;
         c.alu_src_a = 1'b1;
         c.alu_src_b = 2'b10;
         push(c, 1'($urandom), "mem_addr");
         for (int i = 0; i <= wm; i++) begin
            c = '0;
            c.mem_req = 1'b1;
            c.i_or_d = 1'b1;
            c.mem_we = (op == 6'h2b);
            push(c, i == wm, op == 6'h2b ? "mem_write" : "mem_read");
         end
         if (op == 6'h23) begin
            c = '0;
            c.reg_write = 1'b1;
            c.mem_to_reg = 1'b1;
            push(c, 1'($urandom), "mem_wb");
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         c = '0;
         c.aluctrl = 5'b00110;
         c.alu_src_a = 1'b1;
         c.pc_source = 2'b01;
         c.pc_write = (op == 6'h04) ? z : !z;
         push(c, 1'($urandom), "branch");
      end else if (op == 6'h02) begin
         c = '0;
         c.pc_write = 1'b1;
         c.pc_source = 2'b10;
         push(c, 1'($urandom), "jump");
      end else if (i_alu(op) >= 0) begin
         c = '0;
         c.alu_src_a = 1'b1;
         c.alu_src_b = 2'b10;
         c.aluctrl = 5'(i_alu(op));
         push(c, 1'($urandom), "i_exec");
         c = '0;
         c.reg_write = 1'b1;
         push(c, 1'($urandom), "i_wb");
      end else begin
         push_ill();
      end
   endtask

   // Runs up to n queued steps (all when n < 0), then drops the rest
   task automatic run_q(input int n);
      int k = 0;
      while (q.size() > 0 && (n < 0 || k < n)) begin
         step_t s = q.pop_front();
         mem_ready = s.rdy;
         #1;
         check(s.tag, 32'(got), 32'(s.c));
         @(posedge clk);
         #1;
         k++;
      end
      q.delete();
   endtask

   task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int wf, input int wm);
      opcode = op;
      funct = fn;
      zero_in = z;
      build(op, fn, z, wf, wm);
      run_q(-1);
   endtask

   logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04,
                            6'h05, 6'h02, 6'h08, 6'h09, 6'h0c, 6'h0d,
                            6'h0a, 6'h0f};
   logic [5:0] fns [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                            6'h27, 6'h2a, 6'h00, 6'h02, 6'h03};

   task automatic rand_instr();
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                       : ops[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom)
                                       : fns[$urandom_range(0, 10)];
      instr(op, fn, 1'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3));
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset", 32'(got), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle", 32'(got), 32'd0);
      @(posedge clk);
      #1;

      instr(6'h00, 6'h22, 1'b0, 0, 0);
      instr(6'h23, 6'h15, 1'b0, 0, 3);
      instr(6'h04, 6'h00, 1'b1, 0, 0);
      instr(6'h04, 6'h00, 1'b0, 0, 0);
      instr(6'h05, 6'h00, 1'b0, 0, 0);
      instr(6'h0f, 6'h00, 1'b0, 0, 0);
      instr(6'h3f, 6'h00, 1'b0, 0, 0);
      instr(6'h00, 6'h3f, 1'b0, 1, 0);
      instr(6'h2b, 6'h00, 1'b0, 2, 2);

      repeat (300) rand_instr();

      // Abort a store mid-access and make sure it never re-issues
      opcode = 6'h2b;
      funct = 6'h00;
      build(6'h2b, 6'h00, 1'b0, 0, 4);
      run_q(3);
      mem_ready = 1'b0;
      #1;
      check("sw_pre_rst_we", 32'(mem_we), 32'd1);
      rst = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("rst_async", 32'(got), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("rst_hold", 32'(got), 32'd0);
      end
      rst = 1'b0;
      #1;
      check("rst_release_idle", 32'(got), 32'd0);
      @(posedge clk);
      #1;
      check("rst_no_we", 32'(mem_we), 32'd0);

      repeat (50) rand_instr();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
